// File: rtl/spi_periph_pkg.sv
// Shared definitions for the SPI peripheral: register offsets and STATUS layout.
// STATUS bit positions are fixed by the field order of status_t.
package spi_periph_pkg;

   localparam logic [7:0] REG_TXDATA = 8'h00;
   localparam logic [7:0] REG_RXDATA = 8'h04;
   localparam logic [7:0] REG_STATUS = 8'h08;
   localparam logic [7:0] REG_CLEAR  = 8'h0C;

   localparam int CLEAR_OVERRUN_BIT = 3;

   // Packed MSB first: bit4 cs_active ... bit0 rx_not_empty
   typedef struct packed {
      logic cs_active;
      logic overrun;
      logic tx_empty;
      logic rx_full;
      logic rx_not_empty;
   } status_t;

   function automatic logic [31:0] status_word(input status_t s);
      return {27'd0, s};
   endfunction

endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous RX FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
// Pointers carry one extra wrap bit to tell full from empty.
module spi_rx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] head,
   output logic       full,
   output logic       empty
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_reg [DEPTH];
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_reg[wr_ptr_reg[AW-1:0]] <= din;
      end
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/spi_periph.sv
// Memory-mapped SPI target (mode 0, MSB first, 8-bit frames) with RX FIFO and
// a TX holding register; all pins are synchronised into the clk domain.
module spi_periph
   import spi_periph_pkg::*;
#(
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] IDLE_BYTE  = 8'hFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wen,
   input  logic        ren,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        sck,
   input  logic        cs,
   input  logic        mosi,
   output logic        miso,
   output logic        irq
);
   // Pin order {mosi, cs, sck}; idle levels are the synchroniser presets
   localparam logic [2:0] SYNC_PRESET = 3'b010;

   logic [2:0] pin_async;
   logic [2:0] pin_sync;
   logic       sck_s, cs_s, mosi_s;

   assign pin_async = {mosi, cs, sck};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
         if (reset) begin
            meta_reg <= SYNC_PRESET[gi];
            sync_reg <= SYNC_PRESET[gi];
         end else begin
            meta_reg <= pin_async[gi];
            sync_reg <= meta_reg;
         end
      end
      assign pin_sync[gi] = sync_reg;
   end

   assign sck_s  = pin_sync[0];
   assign cs_s   = pin_sync[1];
   assign mosi_s = pin_sync[2];

   logic        sck_d_reg, cs_d_reg;
   logic [2:0]  settle_reg;
   logic        frame_active_reg;
   logic [2:0]  bit_cnt_reg;
   logic [7:0]  sr_in_reg, sr_out_reg;
   logic [7:0]  tx_hold_reg;
   logic        tx_valid_reg;
   logic        overrun_reg;
   logic [31:0] rdata_reg;

   logic        sck_rise, sck_fall, cs_fall, cs_rise;
   logic        shift_in, shift_out, reload;
   logic [7:0]  reload_byte, rx_byte;
   logic        rx_push, rx_pop, bus_rd, wr_tx, wr_clr;
   logic [7:0]  fifo_head;
   logic        fifo_full, fifo_empty;
   status_t     status;

   assign sck_rise  = sck_s && !sck_d_reg;
   assign sck_fall  = !sck_s && sck_d_reg;
   // Only trust a cs fall once the whole pin pipeline holds post-reset samples,
   // so a cs held low across reset never looks like a fresh frame start.
   assign cs_fall   = settle_reg[2] && cs_d_reg && !cs_s;
   assign cs_rise   = cs_s && !cs_d_reg;

   assign shift_in  = frame_active_reg && !cs_rise && !cs_fall && sck_rise;
   assign shift_out = frame_active_reg && !cs_rise && sck_fall;
   assign reload    = cs_fall || (shift_out && (bit_cnt_reg == 3'd0));
   assign reload_byte = tx_valid_reg ? tx_hold_reg : IDLE_BYTE;
   assign rx_byte   = {sr_in_reg[6:0], mosi_s};
   assign rx_push   = shift_in && (bit_cnt_reg == 3'd7);

   assign bus_rd    = ren && !wen;
   assign rx_pop    = bus_rd && (addr[7:0] == REG_RXDATA);
   assign wr_tx     = wen && (addr[7:0] == REG_TXDATA);
   assign wr_clr    = wen && (addr[7:0] == REG_CLEAR) && wdata[CLEAR_OVERRUN_BIT];

   assign status = '{cs_active:    !cs_s,
                     overrun:      overrun_reg,
                     tx_empty:     !tx_valid_reg,
                     rx_full:      fifo_full,
                     rx_not_empty: !fifo_empty};

   spi_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .din   (rx_byte),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_d_reg        <= 1'b0;
         cs_d_reg         <= 1'b1;
         settle_reg       <= 3'b000;
         frame_active_reg <= 1'b0;
         bit_cnt_reg      <= 3'd0;
         sr_in_reg        <= 8'h00;
         sr_out_reg       <= IDLE_BYTE;
         tx_hold_reg      <= 8'h00;
         tx_valid_reg     <= 1'b0;
         overrun_reg      <= 1'b0;
         rdata_reg        <= 32'd0;
      end else begin
         sck_d_reg  <= sck_s;
         cs_d_reg   <= cs_s;
         settle_reg <= {settle_reg[1:0], 1'b1};

         if (cs_fall) begin
            frame_active_reg <= 1'b1;
            bit_cnt_reg      <= 3'd0;
         end else if (cs_rise) begin
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= 3'd0;
         end else if (shift_in) begin
            sr_in_reg   <= rx_byte;
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
         end

         if (reload) begin
            sr_out_reg <= reload_byte;
         end else if (shift_out) begin
            sr_out_reg <= {sr_out_reg[6:0], 1'b1};
         end

         // A bus write beats the reload's clear: the new byte stays pending
         if (wr_tx) begin
            tx_hold_reg  <= wdata[7:0];
            tx_valid_reg <= 1'b1;
         end else if (reload) begin
            tx_valid_reg <= 1'b0;
         end

         if (rx_push && fifo_full && !rx_pop) begin
            overrun_reg <= 1'b1;
         end else if (wr_clr) begin
            overrun_reg <= 1'b0;
         end

         if (bus_rd) begin
            case (addr[7:0])
               REG_TXDATA: rdata_reg <= {24'd0, tx_hold_reg};
               REG_RXDATA: rdata_reg <= fifo_empty ? 32'd0 : {24'd0, fifo_head};
               REG_STATUS: rdata_reg <= status_word(status);
               default:    rdata_reg <= 32'd0;
            endcase
         end
      end
   end

   assign rdata = rdata_reg;
   assign miso  = frame_active_reg ? sr_out_reg[7] : 1'b1;
   assign irq   = !fifo_empty;

   logic unused_bits;
   assign unused_bits = &{1'b0, addr[31:8], wdata[31:8]};

endmodule

// File: tb/tb_spi_periph.sv
// Self-checking bench for spi_periph: bus tasks plus a mode-0 SPI controller,
// with scoreboard queues for RX FIFO contents and bytes returned on miso.
`timescale 1ns/1ps
module tb_spi_periph;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wen = 1'b0;
   logic        ren = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        sck = 1'b0;
   logic        cs = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_rx[$];
   logic [7:0] exp_miso[$];
   logic       m_tx_valid = 1'b0;
   logic [7:0] m_tx_hold = 8'h00;
   logic [7:0] m_next_out = 8'hFF;
   logic       m_overrun = 1'b0;

   always #5 clk = ~clk;

   spi_periph #(
      .FIFO_DEPTH (4),
      .IDLE_BYTE  (8'hFF)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .wen   (wen),
      .ren   (ren),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .sck   (sck),
      .cs    (cs),
      .mosi  (mosi),
      .miso  (miso),
      .irq   (irq)
   );

   task automatic model_reload();
      m_next_out = m_tx_valid ? m_tx_hold : 8'hFF;
      m_tx_valid = 1'b0;
   endtask

   task automatic model_clear();
      exp_rx.delete();
      exp_miso.delete();
      m_tx_valid = 1'b0;
      m_overrun  = 1'b0;
      m_next_out = 8'hFF;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
      addr = {24'd0, a};
      wdata = d;
      wen = 1'b1;
      @(negedge clk);
      wen = 1'b0;
      if (a == 8'h00) begin
         m_tx_hold  = d[7:0];
         m_tx_valid = 1'b1;
      end
      if (a == 8'h0C && d[3]) m_overrun = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
      addr = {24'd0, a};
      ren = 1'b1;
      @(negedge clk);
      ren = 1'b0;
      d = rdata;
   endtask

   task automatic rx_pop_check(input string name);
      logic [31:0] d;
      logic [7:0]  e;
      e = (exp_rx.size() != 0) ? exp_rx.pop_front() : 8'h00;
      bus_read(8'h04, d);
      checks++;
      if (d !== {24'd0, e}) begin
         errors++;
         $display("FAIL %s: rxdata got %h expected %h", name, d, {24'd0, e});
      end else
         $display("rx pop %s: %h", name, d[7:0]);
   endtask

   task automatic frame_begin();
      cs = 1'b0;
      model_reload();
   endtask

   task automatic frame_end();
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
   endtask

   // One byte (or nbits of one) as controller; optional RXDATA pop timed to
   // land on the same clk edge as the final push.
   task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit pop_last);
      logic [7:0] rx;
      logic [7:0] popped;
      logic [7:0] e;
      rx = 8'h00;
      popped = 8'h00;
      if (nbits == 8) exp_miso.push_back(m_next_out);
      for (int b = 0; b < nbits; b++) begin
         mosi = tx[7-b];
         repeat (HALF) @(negedge clk);
         rx = {rx[6:0], miso};
         sck = 1'b1;
         for (int c = 0; c < HALF; c++) begin
            @(negedge clk);
            if (pop_last && b == nbits - 1 && c == 1) begin
               addr = 32'h4;
               ren = 1'b1;
            end
            if (pop_last && b == nbits - 1 && c == 2) begin
               ren = 1'b0;
               popped = rdata[7:0];
            end
         end
         sck = 1'b0;
      end
      if (nbits == 8) begin
         e = exp_miso.pop_front();
         checks++;
         if (rx !== e) begin
            errors++;
            $display("FAIL miso_byte: got %h expected %h", rx, e);
         end else
            $display("spi byte sent %h received %h", tx, rx);
         if (pop_last) begin
            e = exp_rx.pop_front();
            checks++;
            if (popped !== e) begin
               errors++;
               $display("FAIL collision_pop: got %h expected %h", popped, e);
            end else
               $display("collision pop %h", popped);
         end
         if (exp_rx.size() < 4) exp_rx.push_back(tx);
         else m_overrun = 1'b1;
         model_reload();
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      model_clear();
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
      checks++;
      if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", miso); end
      repeat (4) @(negedge clk);
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h04) begin errors++; $display("FAIL reset_status: got %h expected 00000004", d); end
      $display("reset: rdata/irq/miso/status checked");
   endtask

   task automatic test_tx_rx();
      logic [31:0] d;
      bus_write(8'h00, 32'hA5);
      bus_read(8'h00, d);
      checks++;
      if (d !== 32'hA5) begin errors++; $display("FAIL txdata_read: got %h expected 000000a5", d); end
      frame_begin();
      spi_byte(8'h3C, 8, 1'b0);
      frame_end();
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h05) begin errors++; $display("FAIL txrx_status: got %h expected 00000005", d); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL txrx_irq: got %b expected 1", irq); end
      rx_pop_check("txrx");
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL txrx_irq_clear: got %b expected 0", irq); end
   endtask

   task automatic test_back_to_back();
      frame_begin();
      spi_byte(8'h01, 8, 1'b0);
      spi_byte(8'h02, 8, 1'b0);
      frame_end();
      rx_pop_check("b2b_first");
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL b2b_irq_mid: got %b expected 1", irq); end
      rx_pop_check("b2b_second");
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL b2b_irq_end: got %b expected 0", irq); end
      rx_pop_check("b2b_empty");
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      frame_begin();
      for (int i = 0; i < 5; i++) spi_byte(8'h10 + 8'(i), 8, 1'b0);
      frame_end();
      bus_write(8'h00, 32'h99);
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h0B) begin errors++; $display("FAIL overrun_status: got %h expected 0000000b", d); end
      bus_write(8'h0C, 32'h08);
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h03) begin errors++; $display("FAIL overrun_clear: got %h expected 00000003", d); end
      for (int i = 0; i < 4; i++) rx_pop_check("overrun_drain");
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL overrun_irq: got %b expected 0", irq); end
   endtask

   task automatic test_partial();
      frame_begin();
      spi_byte(8'hE3, 5, 1'b0);
      frame_end();
      frame_begin();
      spi_byte(8'h77, 8, 1'b0);
      frame_end();
      rx_pop_check("partial_full_byte");
      rx_pop_check("partial_nothing_else");
   endtask

   task automatic test_pop_collision();
      logic [31:0] d;
      frame_begin();
      for (int i = 0; i < 4; i++) spi_byte(8'h20 + 8'(i), 8, 1'b0);
      spi_byte(8'h24, 8, 1'b1);
      frame_end();
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h07) begin errors++; $display("FAIL collision_status: got %h expected 00000007", d); end
      for (int i = 0; i < 4; i++) rx_pop_check("collision_drain");
   endtask

   task automatic test_reset_midbyte();
      logic [31:0] d;
      bus_read(8'h00, d);
      frame_begin();
      spi_byte(8'hC3, 3, 1'b0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_clear();
      checks++;
      if (rdata !== 32'd0) begin errors++; $display("FAIL midreset_rdata: got %h expected 0", rdata); end
      // cs is still low: clocks without a fresh cs fall must be ignored
      for (int b = 0; b < 8; b++) begin
         mosi = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b expected 0", irq); end
      checks++;
      if (miso !== 1'b1) begin errors++; $display("FAIL midreset_miso: got %b expected 1", miso); end
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h14) begin errors++; $display("FAIL midreset_status: got %h expected 00000014", d); end
      cs = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      frame_begin();
      spi_byte(8'h5A, 8, 1'b0);
      frame_end();
      checks++;
      if (miso !== 1'b1) begin errors++; $display("FAIL idle_miso: got %b expected 1", miso); end
      rx_pop_check("midreset_5a");
      bus_read(8'h08, d);
      checks++;
      if (d !== 32'h04) begin errors++; $display("FAIL midreset_final_status: got %h expected 00000004", d); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_tx_rx();
      test_back_to_back();
      test_overrun();
      test_partial();
      test_pop_collision();
      test_reset_midbyte();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_periph.md
# spi_periph

Memory-mapped SPI peripheral (slave) for the SoC bus: the target end of the existing SPI controller's link, mode 0, MSB first, 8-bit frames, active-low chip select. Pins are synchronised into the system clock domain. Received bytes land in a small RX FIFO. The CPU preloads the next byte to return on `miso` through a TX holding register.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: RX FIFO entries; power of two, ≥2.
- `IDLE_BYTE`, 8'hFF: byte shifted out when no TX byte is pending.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `wen`  in  1  bus write strobe.
- `ren`  in  1  bus read strobe; only reads with `ren` have side effects.
- `addr`  in  32  byte address; only `addr[7:0]` is decoded.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `sck`  in  1  SPI clock from the controller, asynchronous.
- `cs`  in  1  chip select, active low, asynchronous.
- `mosi`  in  1  serial data in, asynchronous.
- `miso`  out  1  serial data out.
- `irq`  out  1  high while the RX FIFO is non-empty.

## Operation
Register map, on `addr[7:0]`:
- 0x00 TXDATA: write loads `wdata[7:0]` into the TX holding register and sets `tx_valid`. A write while `tx_valid` is set overwrites the held byte. Reads return the held byte.
- 0x04 RXDATA: read returns the FIFO head in `[7:0]`. A read with `ren` pops the FIFO. Reading an empty FIFO returns 0 and pops nothing.
- 0x08 STATUS (read-only):
  - bit0 rx_not_empty
  - bit1 rx_full
  - bit2 tx_empty (= !tx_valid)
  - bit3 overrun
  - bit4 cs_active (synchronised `cs` == 0)
  - other bits 0
- 0x0C CLEAR: write with `wdata[3]`=1 clears overrun.
- Unmapped reads return 0. Unmapped writes are ignored.

Pin path:
- `sck`, `cs` and `mosi` each pass through a 2-flop synchroniser.
- A third register on `sck` and `cs` provides edge detection.
- `mosi` is sampled from its synchronised value on the detected `sck` rise.

Frame behaviour:
- cs fall (detected): `bit_cnt`←0. `sr_out` loads the TX holding byte if `tx_valid`, which also clears `tx_valid`; otherwise it loads `IDLE_BYTE`.
- sck rise while cs active: `sr_in`←{`sr_in[6:0]`,mosi}, `bit_cnt`++ (3-bit, wraps). When `bit_cnt` wraps 7→0, the assembled byte is pushed to the FIFO. If the FIFO is full, the byte is dropped and overrun is set (sticky).
- sck fall while cs active: if `bit_cnt`==0, reload `sr_out` by the cs-fall rule (next byte). Otherwise `sr_out`←{`sr_out[6:0]`,1'b1}.
- `miso` = `sr_out[7]` while cs is active, and 1 while cs is inactive.
- cs rise mid-byte: the partial byte is discarded and `bit_cnt`←0. Nothing is pushed, and `tx_valid` is unaffected.
- sck edges seen while cs is inactive are ignored.

## Timing
- Reset values:
  - `rdata`=0, `irq`=0, `miso`=1.
  - FIFO empty, `tx_valid`=0, overrun=0, `bit_cnt`=0.
  - `sr_out`=`IDLE_BYTE`, `sr_in`=0.
  - Synchronisers preset to idle: `sck`=0, `cs`=1, `mosi`=0.
- Reset asserted mid-frame aborts the frame. After reset, a frame is only accepted starting from a fresh cs fall.
- Pin edge to internal action: 3 clk cycles. `miso` changes 3–4 clk cycles after the `sck` fall pin edge.
- Each `sck` half-period must be ≥6 clk cycles. For the team's controller on the same clock, this means `clk_div` ≥5.
- `rdata` is valid 1 cycle after the `ren` cycle.
- Pop and `irq` update on the same clock edge as `rdata`.
- Simultaneous events:
  - Push and pop on the same cycle with the FIFO full: the pop is done first, the push succeeds, and overrun stays clear.
  - TXDATA write on the same cycle as a reload: the reload takes the old held byte (or `IDLE_BYTE` if none). The new byte becomes pending with `tx_valid`=1.
- `wen` and `ren` both set: the write is performed and the read is ignored.

## Structure
- Register offsets (0x00/0x04/0x08/0x0C) and STATUS bit positions go in the shared SPI defines include, alongside the controller's offsets.
- One sub-module: `spi_rx_fifo`, a synchronous FIFO with push, pop, full, empty and head output, parameterised by `FIFO_DEPTH`, using pointers one bit wider than the address.
- Synchroniser, edge detect, shifters and register file stay in the top module.

## Test plan
- Write TXDATA=0xA5, controller sends 0x3C: FIFO holds 0x3C, controller receives 0xA5, STATUS bit2=1 afterwards, `irq`=1.
- No TX byte pending, two-byte frame 0x01,0x02 under one cs low: controller receives 0xFF,0xFF; RXDATA reads return 0x01 then 0x02; `irq` drops after the second pop.
- Send 5 bytes without popping (`FIFO_DEPTH`=4): STATUS=0x0B with cs high (bit1, bit3, bit0 set). The fifth byte is lost. Writing 0x08 to CLEAR makes bit3=0.
- cs deasserted after 5 bits, then a full byte 0x77: FIFO contains only 0x77; the partial byte is not pushed.
- Pop on the exact cycle a byte completes with the FIFO full: no overrun, occupancy stays at 4.
- Reset asserted mid-byte, then byte 0x5A sent: FIFO holds only 0x5A, `miso` is 1 while idle, `rdata`=0 right after reset.
